// File: rtl/id_hazard_stage_day16.sv
// id_hazard_stage_day16: IF/ID capture, 20-bit decode into ID/EX, load-use
// hazard detection with a one-cycle bubble.
// Optional macro HAZARD_STATS_EN adds a saturating stall_count output that
// counts hazard bubbles.
module id_hazard_stage_day16 #(
  parameter int         PC_W    = 8,
  parameter int         INSTR_W = 20,
  parameter logic [3:0] LOAD_OP = 4'h8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               ext_stall,
  input  logic               flush,
  output logic               stall,
  output logic               pc_write,
  output logic               ex_valid,
  output logic [PC_W-1:0]    ex_pc,
  output logic [3:0]         ex_opcode,
  output logic [3:0]         ex_rd,
  output logic [3:0]         ex_rs1,
  output logic [3:0]         ex_rs2,
  output logic [3:0]         ex_imm,
  output logic               ex_mem_read
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifid_t;

  ifid_t      ifid;
  logic [3:0] id_op, id_rd, id_rs1, id_rs2, id_imm;
  logic       uses_rs1, uses_rs2, hazard;

  // Field split of the IF/ID instruction and source-register usage.
  always_comb begin
    id_op    = ifid.instr[19:16];
    id_rd    = ifid.instr[15:12];
    id_rs1   = ifid.instr[11:8];
    id_rs2   = ifid.instr[7:4];
    id_imm   = ifid.instr[3:0];
    uses_rs1 = !(id_op == 4'h0 || id_op == 4'hF);
    uses_rs2 = (id_op >= 4'h1 && id_op <= 4'h7) || id_op == 4'h9;
  end

  // Load in EX whose destination is read by the instruction in ID; r0 never stalls.
  always_comb begin
    hazard = ifid.valid && ex_valid && ex_mem_read && (ex_rd != 4'h0) &&
             ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd));
  end

  assign stall    = ext_stall;
  assign pc_write = !(hazard && !flush);

  // IF/ID: freeze beats flush, flush beats hazard hold; otherwise capture fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifid <= '0;
    end else if (ext_stall) begin
      ifid <= ifid;
    end else if (flush) begin
      ifid <= '0;
    end else if (!hazard) begin
      ifid <= '{valid: 1'b1, pc: if_pc, instr: if_instr};
    end
  end

  // ID/EX: freeze, else bubble on flush or hazard, else take the decoded IF/ID.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_opcode   <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_imm      <= '0;
      ex_mem_read <= 1'b0;
    end else if (!ext_stall) begin
      if (flush || hazard) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_opcode   <= '0;
        ex_rd       <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_imm      <= '0;
        ex_mem_read <= 1'b0;
      end else begin
        ex_valid    <= ifid.valid;
        ex_pc       <= ifid.pc;
        ex_opcode   <= id_op;
        ex_rd       <= id_rd;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_imm      <= id_imm;
        ex_mem_read <= (id_op == LOAD_OP);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Count hazard bubbles actually inserted; saturates, frozen under ext_stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_count <= '0;
    end else if (!ext_stall && !flush && hazard && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/id_hazard_stage_day16.md
Name: id_hazard_stage_day16

Overview:
- Receiving end of the fetch interface.
- Captures the fetch stage's `pc` and `instr` into an IF/ID register, decodes the 20-bit instruction and holds it in an ID/EX register.
- Detects load-use hazards and drives `stall` and `pc_write` back to the fetch stage. Fetch advances its PC only when `!stall && pc_write`.
- Sits between fetch and execute in the 5-stage core.

Parameters:
- PC_W, 8, PC width; matches fetch PC.
- INSTR_W, 20, instruction width; field layout below is fixed for 20.
- LOAD_OP, 4'h8, opcode of the load instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  PC from fetch.
- if_instr  in  INSTR_W  instruction from fetch.
- ext_stall  in  1  back-end freeze request (e.g. memory busy).
- flush  in  1  branch-taken squash of IF/ID and ID stage.
- stall  out  1  to fetch; equals `ext_stall`.
- pc_write  out  1  to fetch; low during a load-use bubble.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  PC_W  ID/EX PC.
- ex_opcode  out  4  ID/EX opcode.
- ex_rd, ex_rs1, ex_rs2  out  4 each  ID/EX register fields.
- ex_imm  out  4  ID/EX immediate.
- ex_mem_read  out  1  ID/EX instruction is a load (`opcode == LOAD_OP`).

Behaviour:
- Instruction fields:
  - opcode = [19:16], rd = [15:12], rs1 = [11:8], rs2 = [7:4], imm = [3:0].
  - Source usage: rs1 is used by all opcodes except 4'h0 (NOP) and 4'hF (JMP). rs2 is used by opcodes 4'h1–4'h7 and 4'h9 (STORE).
  - r0 never causes a hazard.
- Reset (async, `rstn` low): IF/ID valid = 0; all ex_* = 0; ex_valid = 0; `pc_write` = 1; `stall` = 0.
- IF/ID register:
  - Loads `{if_pc, if_instr}` with valid = 1 on each edge when not held.
  - Held when `ext_stall` = 1 or a hazard is active.
  - Cleared (valid = 0) when `flush` = 1.
- Hazard detection (combinational, on the IF/ID contents):
  - hazard = IF/ID valid && ex_valid && ex_mem_read && ex_rd != 0 && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)).
- `pc_write` = !(hazard && !flush).
- ID/EX register, per edge, in priority order:
  1. `ext_stall`: hold everything.
  2. `flush`: load bubble (ex_valid = 0, all fields 0).
  3. hazard: load bubble.
  4. Otherwise: load decoded IF/ID; ex_valid = IF/ID valid.
- Latency:
  - An instruction presented by fetch at edge N appears on ex_* after edge N+1 (two-register path).
  - A load-use pair costs exactly 1 bubble cycle. After the bubble, ex_valid of the load has moved on, so the hazard clears with no extra state.
- Simultaneous events:
  - `ext_stall` with hazard: freeze all; `pc_write` follows hazard; no bubble inserted until `ext_stall` drops.
  - `flush` with hazard: flush wins; `pc_write` = 1.
  - `ext_stall` with `flush`: freeze; flush is ignored for that cycle. The requester must hold `flush` until `ext_stall` is low.
- Reset mid-bubble: all state is cleared; the next edge after reset release captures fetch normally.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output `stall_count` [15:0].
  - Increments on each edge where a bubble is inserted due to hazard.
  - Saturates at 16'hFFFF.
  - Cleared by reset; held during `ext_stall`.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release; fetch streams pc 0..3 with NOPs → ex_pc = 0,1,2,3 on consecutive cycles starting 2 edges after release; `pc_write` = 1 throughout.
- Load r3 (0x8_3_1_0_0) followed by ADD r4,r3,r2 (0x1_4_3_2_0) → one cycle with `pc_write` = 0 and ex_valid = 0 bubble; ADD appears next cycle; `stall_count` = 1.
- Load r0 followed by a consumer of r0 → no hazard; `pc_write` stays 1; no bubble.
- Load r5 followed by JMP with rs1 field = 5 → no hazard because JMP does not use rs1.
- Hazard cycle with `flush` = 1 → IF/ID and ID/EX both bubble; `pc_write` = 1; `stall_count` unchanged.
- `ext_stall` held 3 cycles during a load-use pair → `stall` = 1 and ex_* frozen for 3 cycles; after release, exactly one bubble; then ADD issues.
